// File: rtl/ethii_pkg.sv
// rtl/ethii_pkg.sv - shared Ethernet II constants, keep encodings and unpacker states
package ethii_pkg;

   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [47:0] ETH_MAC_BCAST = 48'hFFFF_FFFF_FFFF;
   localparam int          ETH_HDR_BYTES = 14;

   // MSB-first contiguous byte enables
   localparam logic [3:0] KEEP_1B = 4'b1000;
   localparam logic [3:0] KEEP_2B = 4'b1100;
   localparam logic [3:0] KEEP_3B = 4'b1110;
   localparam logic [3:0] KEEP_4B = 4'b1111;

   typedef enum logic [2:0] {
      W_DST,
      W_DSTSRC,
      W_SRC,
      W_TYPE,
      DATA,
      TAIL,
      DROP
   } unpack_state_t;

endpackage

// File: rtl/ethii_unpacker.sv
// rtl/ethii_unpacker.sv - Ethernet II header strip, filter and 2-byte payload realign
module ethii_unpacker
   import ethii_pkg::*;
#(
   parameter bit MAC_FILTER_EN  = 1'b1,
   parameter bit TYPE_FILTER_EN = 1'b1,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [47:0]      local_mac_i,
   input  logic [31:0]      ethii_ip_udp_tdata_i,
   input  logic             ethii_ip_udp_tvld_i,
   input  logic             ethii_ip_udp_tlast_i,
   input  logic [3:0]       ethii_ip_udp_tkeep_i,
   output logic             ethii_ip_udp_rdy_o,
   output logic [47:0]      hdr_mac_dest_o,
   output logic [47:0]      hdr_mac_src_o,
   output logic [15:0]      hdr_eth_type_o,
   output logic             hdr_mac_vld_o,
   input  logic             hdr_mac_rdy_i,
   output logic [31:0]      user_tdata_o,
   output logic             user_tvld_o,
   output logic             user_tlast_o,
   output logic [3:0]       user_tkeep_o,
   input  logic             user_trdy_i,
   output logic [CNT_W-1:0] drop_cnt_o
);

   unpack_state_t    state_q, state_d;
   logic [47:0]      cap_dst_q, cap_src_q;
   logic [47:0]      hdr_dst_q, hdr_src_q;
   logic [15:0]      hdr_type_q;
   logic             hdr_vld_q;
   logic [31:0]      out_data_q;
   logic [3:0]       out_keep_q;
   logic             out_last_q, out_vld_q;
   logic [15:0]      saved_data_q;
   logic [3:0]       saved_keep_q;
   logic [CNT_W-1:0] drop_cnt_q;

   logic [31:0] in_data;
   logic [3:0]  in_keep;
   logic        in_last;
   logic        orv, hdr_free, mac_ok, type_ok, frame_pass, w3_has_word;
   logic        in_rdy, in_xfer;
   logic        emit, emit_last, hdr_load, drop_inc, save;
   logic [31:0] emit_data;
   logic [3:0]  emit_keep;

   assign in_data  = ethii_ip_udp_tdata_i;
   assign in_keep  = ethii_ip_udp_tkeep_i;
   assign in_last  = ethii_ip_udp_tlast_i;
   assign orv      = ~out_vld_q | user_trdy_i;
   assign hdr_free = ~hdr_vld_q | hdr_mac_rdy_i;

   // Filter compare on the captured dst MAC and the EtherType in the upper half of w3
   assign mac_ok      = !MAC_FILTER_EN || (cap_dst_q == local_mac_i) || (cap_dst_q == ETH_MAC_BCAST);
   assign type_ok     = !TYPE_FILTER_EN || (in_data[31:16] == ETH_TYPE_IPV4);
   assign frame_pass  = mac_ok && type_ok;
   // w3 carries at least one payload byte (p0) only with keep 1110/1111
   assign w3_has_word = (in_keep == KEEP_3B) || (in_keep == KEEP_4B);

   // Input ready per state; a w3 that ends the frame also writes the output stage, so it needs orv too
   always_comb begin
      in_rdy = 1'b0;
      case (state_q)
         W_DST, W_DSTSRC, W_SRC, DROP: in_rdy = 1'b1;
         W_TYPE:                       in_rdy = hdr_free && (orv || !(in_last && w3_has_word));
         DATA:                         in_rdy = orv;
         default:                      in_rdy = 1'b0;
      endcase
   end

   assign in_xfer = ethii_ip_udp_tvld_i && in_rdy;

   // Next state, output-word formation, header load and drop accounting
   always_comb begin
      state_d   = state_q;
      emit      = 1'b0;
      emit_data = '0;
      emit_keep = KEEP_4B;
      emit_last = 1'b0;
      hdr_load  = 1'b0;
      drop_inc  = 1'b0;
      save      = 1'b0;
      case (state_q)
         W_DST: if (in_xfer) begin
            drop_inc = in_last;
            state_d  = in_last ? W_DST : W_DSTSRC;
         end
         W_DSTSRC: if (in_xfer) begin
            drop_inc = in_last;
            state_d  = in_last ? W_DST : W_SRC;
         end
         W_SRC: if (in_xfer) begin
            drop_inc = in_last;
            state_d  = in_last ? W_DST : W_TYPE;
         end
         W_TYPE: if (in_xfer) begin
            if (!frame_pass || (in_last && !w3_has_word)) begin
               drop_inc = 1'b1;
               state_d  = in_last ? W_DST : DROP;
            end else begin
               hdr_load = 1'b1;
               if (in_last) begin
                  emit      = 1'b1;
                  emit_last = 1'b1;
                  state_d   = W_DST;
                  if (in_keep == KEEP_4B) begin
                     emit_data = {in_data[15:0], 16'h0};
                     emit_keep = KEEP_2B;
                  end else begin
                     emit_data = {in_data[15:8], 24'h0};
                     emit_keep = KEEP_1B;
                  end
               end else begin
                  save    = 1'b1;
                  state_d = DATA;
               end
            end
         end
         DATA: if (in_xfer) begin
            emit      = 1'b1;
            emit_data = {saved_data_q, in_data[31:16]};
            save      = 1'b1;
            if (in_last) begin
               if (in_keep == KEEP_1B) begin
                  emit_keep = KEEP_3B;
                  emit_last = 1'b1;
                  state_d   = W_DST;
               end else if (in_keep == KEEP_2B) begin
                  emit_last = 1'b1;
                  state_d   = W_DST;
               end else begin
                  state_d   = TAIL;
               end
            end
         end
         TAIL: if (orv) begin
            emit      = 1'b1;
            emit_data = {saved_data_q, 16'h0};
            emit_keep = (saved_keep_q == KEEP_4B) ? KEEP_2B : KEEP_1B;
            emit_last = 1'b1;
            state_d   = W_DST;
         end
         DROP: if (in_xfer && in_last) state_d = W_DST;
         default: state_d = W_DST;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= W_DST;
      else          state_q <= state_d;
   end

   // Capture MAC fields as they stream in, kept apart from the header still being presented
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_dst_q <= '0;
         cap_src_q <= '0;
      end else if (in_xfer) begin
         case (state_q)
            W_DST:    cap_dst_q[47:16] <= in_data;
            W_DSTSRC: begin
               cap_dst_q[15:0]  <= in_data[31:16];
               cap_src_q[47:32] <= in_data[15:0];
            end
            W_SRC:    cap_src_q[31:0] <= in_data;
            default:  ;
         endcase
      end
   end

   // Header sideband register; a new load wins over a same-cycle consume
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hdr_vld_q  <= 1'b0;
         hdr_dst_q  <= '0;
         hdr_src_q  <= '0;
         hdr_type_q <= '0;
      end else if (hdr_load) begin
         hdr_vld_q  <= 1'b1;
         hdr_dst_q  <= cap_dst_q;
         hdr_src_q  <= cap_src_q;
         hdr_type_q <= in_data[31:16];
      end else if (hdr_mac_rdy_i) begin
         hdr_vld_q  <= 1'b0;
      end
   end

   // Single-register payload output stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_keep_q <= '0;
         out_last_q <= 1'b0;
      end else if (emit) begin
         out_vld_q  <= 1'b1;
         out_data_q <= emit_data;
         out_keep_q <= emit_keep;
         out_last_q <= emit_last;
      end else if (user_trdy_i) begin
         out_vld_q  <= 1'b0;
      end
   end

   // Low half of the last accepted word and its keep, carried into the next output word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         saved_data_q <= '0;
         saved_keep_q <= '0;
      end else if (save) begin
         saved_data_q <= in_data[15:0];
         saved_keep_q <= in_keep;
      end
   end

   // Dropped-frame counter, wraps naturally
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      drop_cnt_q <= '0;
      else if (drop_inc) drop_cnt_q <= drop_cnt_q + 1'b1;
   end

   assign ethii_ip_udp_rdy_o = in_rdy;
   assign hdr_mac_dest_o     = hdr_dst_q;
   assign hdr_mac_src_o      = hdr_src_q;
   assign hdr_eth_type_o     = hdr_type_q;
   assign hdr_mac_vld_o      = hdr_vld_q;
   assign user_tdata_o       = out_data_q;
   assign user_tvld_o        = out_vld_q;
   assign user_tlast_o       = out_last_q;
   assign user_tkeep_o       = out_keep_q;
   assign drop_cnt_o         = drop_cnt_q;

endmodule

// File: tb/tb_ethii_unpacker.sv
// tb/tb_ethii_unpacker.sv - randomized self-checking bench for ethii_unpacker
module tb_ethii_unpacker;

   localparam logic [47:0] LOCAL_MAC = 48'h0200_0000_0001;
   localparam logic [47:0] SRC_MAC   = 48'h0A0B_0C0D_0E0F;
   localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] in_tdata;
   logic        in_tvld, in_tlast;
   logic [3:0]  in_tkeep;
   logic        in_rdy;
   logic [47:0] hdr_dst, hdr_src;
   logic [15:0] hdr_type;
   logic        hdr_vld, hdr_rdy;
   logic [31:0] u_tdata;
   logic        u_tvld, u_tlast, u_trdy;
   logic [3:0]  u_tkeep;
   logic [15:0] drop_cnt;

   typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } pay_t;
   typedef struct { logic [47:0] dst; logic [47:0] src; logic [15:0] typ; } hdr_t;

   pay_t       exp_pay[$];
   hdr_t       exp_hdr[$];
   logic [7:0] fb[$];
   int n_cmp = 0, n_bad = 0, exp_drops = 0;
   int pay_mode = 0, hdr_mode = 0;
   int hdr_taken = 0, pay_frame = 0;
   bit pay_first = 1'b1, pay_pend = 1'b0, hdr_pend = 1'b0;
   logic [31:0] pay_prev;
   logic [47:0] hdr_prev;

   always #5 clk = ~clk;

   ethii_unpacker dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .local_mac_i          (LOCAL_MAC),
      .ethii_ip_udp_tdata_i (in_tdata),
      .ethii_ip_udp_tvld_i  (in_tvld),
      .ethii_ip_udp_tlast_i (in_tlast),
      .ethii_ip_udp_tkeep_i (in_tkeep),
      .ethii_ip_udp_rdy_o   (in_rdy),
      .hdr_mac_dest_o       (hdr_dst),
      .hdr_mac_src_o        (hdr_src),
      .hdr_eth_type_o       (hdr_type),
      .hdr_mac_vld_o        (hdr_vld),
      .hdr_mac_rdy_i        (hdr_rdy),
      .user_tdata_o         (u_tdata),
      .user_tvld_o          (u_tvld),
      .user_tlast_o         (u_tlast),
      .user_tkeep_o         (u_tkeep),
      .user_trdy_i          (u_trdy),
      .drop_cnt_o           (drop_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] kmask(input logic [3:0] k);
      return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
   endfunction

   task automatic build_frame(input logic [47:0] dst, input logic [15:0] typ, input int plen, input bit seq);
      fb.delete();
      for (int b = 0; b < 6; b++) fb.push_back(dst[47-8*b -: 8]);
      for (int b = 0; b < 6; b++) fb.push_back(SRC_MAC[47-8*b -: 8]);
      fb.push_back(typ[15:8]);
      fb.push_back(typ[7:0]);
      for (int i = 0; i < plen; i++) fb.push_back(seq ? 8'(i) : 8'($urandom));
   endtask

   // Reference: a frame shorter than 15 bytes or failing the filter is one drop;
   // otherwise one header plus the payload bytes (from byte 14) packed 4 per word.
   task automatic model_frame();
      int L = fb.size();
      hdr_t h;
      pay_t p;
      if (L < 15) begin
         exp_drops++;
         return;
      end
      h.dst = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
      h.src = {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]};
      h.typ = {fb[12], fb[13]};
      if (!((h.dst == LOCAL_MAC || h.dst == BCAST) && h.typ == 16'h0800)) begin
         exp_drops++;
         return;
      end
      exp_hdr.push_back(h);
      for (int wk = 0; 14 + 4*wk < L; wk++) begin
         p.data = '0;
         p.keep = '0;
         for (int b = 0; b < 4; b++) begin
            if (14 + 4*wk + b < L) begin
               p.data[31-8*b -: 8] = fb[14 + 4*wk + b];
               p.keep[3-b]         = 1'b1;
            end
         end
         p.last = (14 + 4*wk + 4 >= L);
         exp_pay.push_back(p);
      end
   endtask

   task automatic get_word(input int w, output logic [31:0] d, output logic [3:0] k, output logic l);
      int nw = (fb.size() + 3) / 4;
      d = '0;
      k = '0;
      for (int b = 0; b < 4; b++) begin
         if (4*w + b < fb.size()) begin
            d[31-8*b -: 8] = fb[4*w + b];
            k[3-b]         = 1'b1;
         end else begin
            d[31-8*b -: 8] = 8'($urandom);
         end
      end
      l = (w == nw - 1);
   endtask

   task automatic wait_accept();
      int t  = 0;
      bit ok = 1'b0;
      while (!ok && t < 3000) begin
         @(negedge clk);
         ok = in_rdy;
         t++;
      end
      chk("in_accept", 64'(ok), 64'(1));
   endtask

   task automatic send_range(input int a, input int b);
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      for (int w = a; w <= b; w++) begin
         get_word(w, d, k, l);
         @(posedge clk); #1;
         in_tdata = d; in_tkeep = k; in_tlast = l; in_tvld = 1'b1;
         wait_accept();
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_tvld = 1'b0;
   endtask

   task automatic send_frame();
      send_range(0, (fb.size() + 3) / 4 - 1);
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk("drain_pay_left", 64'(exp_pay.size()), 64'(0));
      chk("drain_hdr_left", 64'(exp_hdr.size()), 64'(0));
      chk("drop_cnt", 64'(drop_cnt), 64'(16'(exp_drops)));
   endtask

   task automatic stall_driver();
      forever begin
         @(posedge clk); #1;
         u_trdy  = (pay_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         hdr_rdy = (hdr_mode == 1) ? 1'b0 : (hdr_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   endtask

   task automatic pay_monitor();
      pay_t e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (pay_pend) begin
               chk("pay_vld_held", 64'(u_tvld), 64'(1));
               chk("pay_data_held", 64'(u_tdata), 64'(pay_prev));
            end
            pay_pend = u_tvld && !u_trdy;
            pay_prev = u_tdata;
            if (u_tvld && u_trdy) begin
               if (pay_first) chk("hdr_before_pay", 64'((hdr_taken > pay_frame) || hdr_vld), 64'(1));
               chk("pay_expected", 64'(exp_pay.size() > 0), 64'(1));
               if (exp_pay.size() > 0) begin
                  e = exp_pay.pop_front();
                  chk("pay_data", 64'(u_tdata & kmask(e.keep)), 64'(e.data));
                  chk("pay_keep", 64'(u_tkeep), 64'(e.keep));
                  chk("pay_last", 64'(u_tlast), 64'(e.last));
               end
               pay_first = u_tlast;
               if (u_tlast) pay_frame++;
            end
         end
      end
   endtask

   task automatic hdr_monitor();
      hdr_t h;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (hdr_pend) begin
               chk("hdr_vld_held", 64'(hdr_vld), 64'(1));
               chk("hdr_dst_held", 64'(hdr_dst), 64'(hdr_prev));
            end
            hdr_pend = hdr_vld && !hdr_rdy;
            hdr_prev = hdr_dst;
            if (hdr_vld && hdr_rdy) begin
               chk("hdr_expected", 64'(exp_hdr.size() > 0), 64'(1));
               if (exp_hdr.size() > 0) begin
                  h = exp_hdr.pop_front();
                  chk("hdr_dst", 64'(hdr_dst), 64'(h.dst));
                  chk("hdr_src", 64'(hdr_src), 64'(h.src));
                  chk("hdr_type", 64'(hdr_type), 64'(h.typ));
               end
               hdr_taken++;
            end
         end
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      logic [47:0] dst;
      int          nw, plen;
      reset_n = 1'b0;
      in_tvld = 1'b0; in_tdata = '0; in_tlast = 1'b0; in_tkeep = '0;
      u_trdy = 1'b0; hdr_rdy = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_user_tvld", 64'(u_tvld), 64'(0));
      chk("rst_hdr_vld", 64'(hdr_vld), 64'(0));
      chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
      chk("rst_in_rdy", 64'(in_rdy), 64'(1));
      reset_n = 1'b1;
      fork
         stall_driver();
         pay_monitor();
         hdr_monitor();
      join_none

      // Unicast IPv4 with sequential payloads of 46, 47 and 48 bytes
      for (int n = 46; n <= 48; n++) begin
         build_frame(LOCAL_MAC, 16'h0800, n, 1'b1);
         model_frame();
         send_frame();
      end
      idle();
      drain();

      // Broadcast ARP dropped, followed back-to-back by a good frame
      build_frame(BCAST, 16'h0806, 46, 1'b1);
      model_frame();
      send_frame();
      build_frame(LOCAL_MAC, 16'h0800, 50, 1'b0);
      model_frame();
      send_frame();
      idle();
      drain();

      // Runt ending on w2, zero-payload w3, then a good frame parsed from w0
      build_frame(LOCAL_MAC, 16'h0800, 30, 1'b0);
      fb = fb[0:11];
      model_frame();
      send_frame();
      build_frame(LOCAL_MAC, 16'h0800, 0, 1'b0);
      model_frame();
      send_frame();
      build_frame(LOCAL_MAC, 16'h0800, 1, 1'b0);
      model_frame();
      send_frame();
      build_frame(BCAST, 16'h0800, 3, 1'b0);
      model_frame();
      send_frame();
      idle();
      drain();

      // Header held off: the second frame's w3 must wait for the first header
      hdr_mode = 1;
      @(posedge clk); #2;
      build_frame(LOCAL_MAC, 16'h0800, 2, 1'b0);
      model_frame();
      send_frame();
      build_frame(BCAST, 16'h0800, 10, 1'b0);
      model_frame();
      send_range(0, 2);
      get_word(3, d, k, l);
      @(posedge clk); #1;
      in_tdata = d; in_tkeep = k; in_tlast = l; in_tvld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("w_type_held_off", 64'(in_rdy), 64'(0));
      end
      hdr_mode = 2;
      wait_accept();
      send_range(4, (fb.size() + 3) / 4 - 1);
      idle();
      drain();
      hdr_mode = 0;

      // Randomized frames with 50% stalls on both output handshakes
      for (int f = 0; f < 100; f++) begin
         case ($urandom_range(0, 9))
            0:       dst = {16'($urandom), 32'($urandom)};
            1:       dst = BCAST;
            default: dst = LOCAL_MAC;
         endcase
         plen = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(46, 1500));
         build_frame(dst, ($urandom_range(0, 9) == 0) ? 16'h0806 : 16'h0800, plen, 1'b0);
         model_frame();
         send_frame();
         if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(1, 3)) @(posedge clk);
         end
      end
      idle();
      drain();

      // Asynchronous reset in mid-payload
      build_frame(LOCAL_MAC, 16'h0800, 200, 1'b0);
      model_frame();
      send_range(0, 20);
      @(posedge clk); #1;
      in_tvld = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk("midrst_user_tvld", 64'(u_tvld), 64'(0));
      chk("midrst_hdr_vld", 64'(hdr_vld), 64'(0));
      chk("midrst_drop_cnt", 64'(drop_cnt), 64'(0));
      exp_pay.delete();
      exp_hdr.delete();
      exp_drops = 0; hdr_taken = 0; pay_frame = 0;
      pay_first = 1'b1; pay_pend = 1'b0; hdr_pend = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      build_frame(LOCAL_MAC, 16'h0800, 47, 1'b1);
      model_frame();
      send_frame();
      idle();
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
